// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_pkg
// Brief    : Shared types and constants for the EX-stage forwarding unit.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_hazard_unit_pkg;

  // Tracker entries carry addresses zero-extended to this width so that one
  // packed struct type can serve any ADDRESS_LEN up to this value.
  localparam int c_ADDR_MAX = 8;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // One producer slot of the tracker: valid, destination address, load flag.
  typedef struct packed {
    logic                  v;
    logic [c_ADDR_MAX-1:0] addr;
    logic                  ld;
  } trk_entry_t;

  // Width of a forward select able to encode 0..stages.
  function automatic int fwd_len(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match_prio.sv
`default_nettype none
// ============================================================================
// Module   : fwd_match_prio
// Brief    : Finds the youngest tracker entry whose destination matches one
//            source operand; reports its stage, its load flag and any-hit.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int FWD_STAGES  = 2,
  parameter int FORWARD_LEN = fwd_len(FWD_STAGES)
) (
  input  trk_entry_t [FWD_STAGES:1] entries,
  input  logic [c_ADDR_MAX-1:0]     src_addr,
  input  logic                      src_en,
  output logic [FORWARD_LEN-1:0]    hit_k,
  output logic                      hit_ld,
  output logic                      any_hit
);

  // Scan oldest to youngest so the smallest matching stage overwrites the rest.
  always_comb begin
    hit_k   = FORWARD_LEN'(FWD_RF);
    hit_ld  = 1'b0;
    any_hit = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (src_en && entries[k].v && (entries[k].addr == src_addr)) begin
        hit_k   = FORWARD_LEN'(k);
        hit_ld  = entries[k].ld;
        any_hit = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : EX-stage forwarding select and load-use stall generator with a
//            private history of the last FWD_STAGES producers.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDRESS_LEN = 5,
  parameter int NUM_SRC     = 2,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_STAGE  = 2,
  parameter int FORWARD_LEN = fwd_len(FWD_STAGES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ex_valid,
  input  logic [NUM_SRC*ADDRESS_LEN-1:0] ex_rd_addr,
  input  logic [NUM_SRC-1:0]             ex_src_used,
  input  logic                           ex_reg_write,
  input  logic [ADDRESS_LEN-1:0]         ex_wr_addr,
  input  logic                           ex_is_load,
  input  logic                           hold,
  input  logic                           flush,
  output logic [NUM_SRC*FORWARD_LEN-1:0] forward_sel,
  output logic                           stall_ex,
  output logic [FORWARD_LEN-1:0]         stall_cnt
);

  localparam logic [FORWARD_LEN-1:0] c_LOAD_K = FORWARD_LEN'(LOAD_STAGE);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  trk_entry_t [FWD_STAGES:1]  r_trk;
  trk_entry_t                 w_new;
  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [FORWARD_LEN-1:0]     w_hit_k  [NUM_SRC];
  logic [FORWARD_LEN-1:0]     w_need   [NUM_SRC];
  logic [NUM_SRC-1:0]         w_hit_ld;
  logic [NUM_SRC-1:0]         w_any_hit;
  logic [NUM_SRC-1:0]         w_lu;
  logic [FORWARD_LEN-1:0]     w_cnt;

  // Producer entering stage 1; writes to x0 are never tracked.
  assign w_new.v    = ex_valid & ex_reg_write & (|ex_wr_addr);
  assign w_new.addr = c_ADDR_MAX'(ex_wr_addr);
  assign w_new.ld   = ex_is_load;

  // Per-operand match, select and load-use demand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDRESS_LEN-1:0] w_rd;
    logic                   w_en;

    assign w_rd = ex_rd_addr[i*ADDRESS_LEN +: ADDRESS_LEN];
    assign w_en = ex_src_used[i] & ex_valid & (|w_rd);

    fwd_match_prio #(
      .FWD_STAGES  (FWD_STAGES),
      .FORWARD_LEN (FORWARD_LEN)
    ) u_match (
      .entries  (r_trk),
      .src_addr (c_ADDR_MAX'(w_rd)),
      .src_en   (w_en),
      .hit_k    (w_hit_k[i]),
      .hit_ld   (w_hit_ld[i]),
      .any_hit  (w_any_hit[i])
    );

    // Only the youngest match counts: an older, ready producer is no fallback.
    assign w_lu[i]   = w_any_hit[i] & w_hit_ld[i] & (w_hit_k[i] < c_LOAD_K);
    assign w_need[i] = w_lu[i] ? (c_LOAD_K - w_hit_k[i]) : '0;

    assign forward_sel[i*FORWARD_LEN +: FORWARD_LEN] = w_hit_k[i];
  end

  // Longest outstanding load latency across all stalling operands.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_need[i] > w_cnt) begin
        w_cnt = w_need[i];
      end
    end
  end

  assign stall_ex  = |w_lu;
  assign stall_cnt = w_cnt;

  // Producer history: flush beats hold beats stall-bubble beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trk <= '0;
    end else if (flush) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_trk[k].v <= 1'b0;
      end
    end else if (!hold) begin
      for (int k = 2; k <= FWD_STAGES; k++) begin
        r_trk[k] <= r_trk[k-1];
      end
      r_trk[1] <= stall_ex ? trk_entry_t'('0) : w_new;
    end
  end

  // Debug-visible RUN/STALL state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN/STALL next-state follows the combinational stall request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (stall_ex && !flush) w_state_nxt = ST_STALL;
      ST_STALL: if (flush || (w_cnt == '0)) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed self-checking bench for fwd_hazard_unit, default and
//            3-source / 3-stage configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst;

  // Configuration A: defaults (NUM_SRC=2, FWD_STAGES=2, LOAD_STAGE=2)
  logic       a_valid, a_we, a_ld, a_hold, a_flush;
  logic [9:0] a_rd;
  logic [1:0] a_used;
  logic [4:0] a_wa;
  logic [3:0] a_sel;
  logic       a_stall;
  logic [1:0] a_cnt;

  // Configuration B: NUM_SRC=3, FWD_STAGES=3, LOAD_STAGE=3
  logic        b_valid, b_we, b_ld, b_hold, b_flush;
  logic [14:0] b_rd;
  logic [2:0]  b_used;
  logic [4:0]  b_wa;
  logic [5:0]  b_sel;
  logic        b_stall;
  logic [1:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (a_valid),
    .ex_rd_addr   (a_rd),
    .ex_src_used  (a_used),
    .ex_reg_write (a_we),
    .ex_wr_addr   (a_wa),
    .ex_is_load   (a_ld),
    .hold         (a_hold),
    .flush        (a_flush),
    .forward_sel  (a_sel),
    .stall_ex     (a_stall),
    .stall_cnt    (a_cnt)
  );

  fwd_hazard_unit #(
    .ADDRESS_LEN (5),
    .NUM_SRC     (3),
    .FWD_STAGES  (3),
    .LOAD_STAGE  (3)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (b_valid),
    .ex_rd_addr   (b_rd),
    .ex_src_used  (b_used),
    .ex_reg_write (b_we),
    .ex_wr_addr   (b_wa),
    .ex_is_load   (b_ld),
    .hold         (b_hold),
    .flush        (b_flush),
    .forward_sel  (b_sel),
    .stall_ex     (b_stall),
    .stall_cnt    (b_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] used, input logic we, input logic [4:0] wa,
                       input logic ld);
    a_valid = v; a_rd = {r1, r0}; a_used = used; a_we = we; a_wa = wa; a_ld = ld;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [2:0] used, input logic we,
                       input logic [4:0] wa, input logic ld);
    b_valid = v; b_rd = {r2, r1, r0}; b_used = used; b_we = we; b_wa = wa; b_ld = ld;
  endtask

  task automatic chk_a(input string tag, input int sel, input int stall, input int cnt);
    check({tag, ".sel"},   int'(a_sel),   sel);
    check({tag, ".stall"}, int'(a_stall), stall);
    check({tag, ".cnt"},   int'(a_cnt),   cnt);
  endtask

  task automatic chk_b(input string tag, input int sel, input int stall, input int cnt);
    check({tag, ".sel"},   int'(b_sel),   sel);
    check({tag, ".stall"}, int'(b_stall), stall);
    check({tag, ".cnt"},   int'(b_cnt),   cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_hold = 1'b0; a_flush = 1'b0; b_hold = 1'b0; b_flush = 1'b0;
    set_a(0, 0, 0, 2'b00, 0, 0, 0);
    set_b(0, 0, 0, 0, 3'b000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_a("reset_a", 0, 0, 0);
    chk_b("reset_b", 0, 0, 0);

    // Producers x7 then x5
    set_a(1, 0, 0, 2'b00, 1, 7, 0); #1; tick;
    set_a(1, 0, 0, 2'b00, 1, 5, 0); #1; tick;
    // Reads x5 (stage 1) and x7 (stage 2), itself writes x5
    set_a(1, 5, 7, 2'b11, 1, 5, 0); #1;
    chk_a("x5_x7", 4'b1001, 0, 0);
    tick;
    // x5 at both stages: youngest wins on both operands
    set_a(1, 5, 5, 2'b11, 0, 0, 0); #1;
    chk_a("youngest", 4'b0101, 0, 0);
    tick;
    // Only op0 used; load to x0 entered this cycle
    set_a(1, 5, 5, 2'b01, 1, 0, 1); #1;
    chk_a("src_used", 4'b0010, 0, 0);
    tick;
    // Reads of x0 never forward; load x8 enters
    set_a(1, 0, 0, 2'b11, 1, 8, 1); #1;
    chk_a("x0_read", 0, 0, 0);
    tick;
    // Load-use: add x9,x8,x0
    set_a(1, 8, 0, 2'b11, 1, 9, 0); #1;
    chk_a("lu_stall", 4'b0001, 1, 1);
    tick;
    #1;
    chk_a("lu_release", 4'b0010, 0, 0);
    tick;

    // Flush during a load-use stall
    set_a(1, 0, 0, 2'b00, 1, 10, 1); #1; tick;
    set_a(1, 10, 9, 2'b11, 1, 11, 0); #1;
    chk_a("pre_flush", 4'b1001, 1, 1);
    a_flush = 1'b1;
    tick;
    a_flush = 1'b0; #1;
    chk_a("post_flush", 0, 0, 0);
    tick;
    // flush and hold together clear the tracker
    set_a(1, 11, 0, 2'b01, 0, 0, 0); #1;
    chk_a("pre_flush_hold", 4'b0001, 0, 0);
    a_flush = 1'b1; a_hold = 1'b1;
    tick;
    a_flush = 1'b0; a_hold = 1'b0; #1;
    chk_a("post_flush_hold", 0, 0, 0);
    tick;

    // Hold for 3 cycles with a load at stage 1
    set_a(1, 0, 0, 2'b00, 1, 12, 1); #1; tick;
    set_a(1, 12, 0, 2'b01, 1, 13, 0);
    a_hold = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk_a("hold_stall", 4'b0001, 1, 1);
      tick;
    end
    a_hold = 1'b0; #1;
    chk_a("hold_release", 4'b0001, 1, 1);
    tick;
    #1;
    chk_a("after_hold", 4'b0010, 0, 0);
    tick;

    // Reset in the middle of a stall
    set_a(1, 0, 0, 2'b00, 1, 14, 1); #1; tick;
    set_a(1, 14, 0, 2'b01, 0, 0, 0); #1;
    chk_a("pre_rst", 4'b0001, 1, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    chk_a("post_rst", 0, 0, 0);
    set_a(0, 0, 0, 2'b00, 0, 0, 0);
    tick;

    // Config B: load x8, consumer on op0 and op2
    set_b(1, 0, 0, 0, 3'b000, 1, 8, 1); #1; tick;
    set_b(1, 8, 0, 8, 3'b111, 1, 9, 0); #1;
    chk_b("b_cnt2", 6'h11, 1, 2);
    tick;
    #1;
    chk_b("b_cnt1", 6'h22, 1, 1);
    tick;
    // Load reaches stage 3; this instruction is itself a load of x20
    set_b(1, 8, 0, 8, 3'b111, 1, 20, 1); #1;
    chk_b("b_release", 6'h33, 0, 0);
    tick;
    set_b(1, 0, 0, 0, 3'b000, 1, 21, 1); #1;
    chk_b("b_noread", 0, 0, 0);
    tick;
    // Two pending loads: count is the larger demand
    set_b(1, 20, 21, 0, 3'b011, 0, 0, 0); #1;
    chk_b("b_max", 6'h06, 1, 2);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
